// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM CPU front end: word width, opcode values and
// the fetch sequencer state encoding.
package hrm_pkg;

    localparam int WORD_W = 8;

    localparam logic [WORD_W-1:0] OP_INBOX    = 8'h00;
    localparam logic [WORD_W-1:0] OP_OUTBOX   = 8'h10;
    localparam logic [WORD_W-1:0] OP_COPYFROM = 8'h20;
    localparam logic [WORD_W-1:0] OP_COPYTO   = 8'h30;
    localparam logic [WORD_W-1:0] OP_ADD      = 8'h40;
    localparam logic [WORD_W-1:0] OP_SUB      = 8'h50;
    localparam logic [WORD_W-1:0] OP_BUMPUP   = 8'h60;
    localparam logic [WORD_W-1:0] OP_BUMPDN   = 8'h70;
    localparam logic [WORD_W-1:0] OP_JUMP     = 8'h80;
    localparam logic [WORD_W-1:0] OP_JUMPZ    = 8'h90;
    localparam logic [WORD_W-1:0] OP_JUMPN    = 8'hA0;
    localparam logic [WORD_W-1:0] OP_HALT     = 8'hF0;

    // FAULT is only reachable when fetch bounds checking is compiled in.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_OP  = 3'd1,
        WAIT_OP   = 3'd2,
        FETCH_ARG = 3'd3,
        WAIT_ARG  = 3'd4,
        ISSUE     = 3'd5,
        HALTED    = 3'd6,
        FAULT     = 3'd7
    } fetch_state_e;

endpackage

// File: rtl/hrm_opclass.sv
// Combinational opcode classifier: does the opcode carry an operand byte, and
// is it HALT. Shared by the fetch sequencer and the decoder.
module hrm_opclass
    import hrm_pkg::*;
(
    input  logic [WORD_W-1:0] op,
    output logic              needs_arg,
    output logic              is_halt
);

    // Operand-carrying opcodes occupy the contiguous high-nibble range COPYFROM..JUMPN.
    assign needs_arg = (op[7:4] >= OP_COPYFROM[7:4]) && (op[7:4] <= OP_JUMPN[7:4]);
    assign is_halt   = (op == OP_HALT);

endmodule

// File: rtl/hrm_fetch_ctrl.sv
// HRM instruction-fetch sequencer: owns the PC, reads the synchronous ROM and
// issues opcode/operand pairs to the decoder. Optional macro: FETCH_BOUNDS_EN.
module hrm_fetch_ctrl
    import hrm_pkg::*;
#(
    parameter int                SIZE     = 256,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [WORD_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_op,
    output logic [WORD_W-1:0] instr_arg,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              halted,
    output logic              fault,
    output fetch_state_e      state
);

`ifdef FETCH_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    // Handshake: the decoder takes the instruction on any rising edge where
    // instr_valid and instr_ready are both high; op/arg/pc hold until then.
    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] op_q, op_d;
    logic [WORD_W-1:0] arg_q, arg_d;
    logic [WORD_W-1:0] ipc_q, ipc_d;
    logic [WORD_W-1:0] dec_op;
    logic              dec_needs_arg;
    logic              dec_is_halt;
    logic              pc_oob;

    // The classifier looks at the byte arriving from ROM while it is being
    // latched, and at the held opcode otherwise.
    assign dec_op = (state_q == WAIT_OP) ? rom_data : op_q;

    hrm_opclass u_opclass (
        .op        (dec_op),
        .needs_arg (dec_needs_arg),
        .is_halt   (dec_is_halt)
    );

    assign pc_oob = BOUNDS_EN && (int'(pc_q) >= SIZE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        arg_d   = arg_q;
        ipc_d   = ipc_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH_OP;
            end
            FETCH_OP: begin
                if (pc_oob) begin
                    state_d = FAULT;
                end else begin
                    ipc_d   = pc_q;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                op_d    = rom_data;
                arg_d   = '0;
                pc_d    = pc_q + 8'd1;
                state_d = dec_needs_arg ? FETCH_ARG : ISSUE;
            end
            FETCH_ARG: begin
                state_d = pc_oob ? FAULT : WAIT_ARG;
            end
            WAIT_ARG: begin
                arg_d   = rom_data;
                pc_d    = pc_q + 8'd1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (dec_is_halt) begin
                        state_d = HALTED;
                    end else begin
                        if (branch_taken) pc_d = branch_target;
                        state_d = run ? FETCH_OP : IDLE;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            op_q    <= '0;
            arg_q   <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            ipc_q   <= ipc_d;
        end
    end

    assign rom_addr    = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign instr_op    = op_q;
    assign instr_arg   = arg_q;
    assign instr_pc    = ipc_q;
    assign halted      = (state_q == HALTED) || (state_q == FAULT);
    assign state       = state_q;

`ifdef FETCH_BOUNDS_EN
    assign fault = (state_q == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_hrm_fetch_ctrl.sv
// Directed self-checking bench for hrm_fetch_ctrl: small ROM programs with
// hand-computed issue sequences, stalls, branches, reset and bounds cases.
module tb_hrm_fetch_ctrl;
    import hrm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instr_op;
    logic [7:0] instr_arg;
    logic [7:0] instr_pc;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       halted;
    logic       fault;
    fetch_state_e state;

    // second instance with a 3-word ROM, for the bounds scenario
    logic [7:0]   rom_addr_b;
    logic [7:0]   rom_data_b;
    logic         instr_valid_b;
    logic [7:0]   op_b;
    logic [7:0]   arg_b;
    logic [7:0]   pc_b;
    logic         halted_b;
    logic         fault_b;
    fetch_state_e state_b;

    logic [7:0]  rom [256];
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [23:0] obs_b[$];
    int          obs_cyc[$];
    int          cyc = 0;
    int          fetch_cyc = -1;
    int          valid_cyc = -1;
    int          halt_cyc  = -1;
    int          n_checks  = 0;
    int          n_errors  = 0;

    hrm_fetch_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_arg(instr_arg), .instr_pc(instr_pc), .branch_taken(branch_taken),
        .branch_target(branch_target), .halted(halted), .fault(fault), .state(state)
    );

    hrm_fetch_ctrl #(.SIZE(3)) dut_b (
        .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready), .instr_op(op_b),
        .instr_arg(arg_b), .instr_pc(pc_b), .branch_taken(1'b0),
        .branch_target(8'h00), .halted(halted_b), .fault(fault_b), .state(state_b)
    );

    // clock / reset / ROM models
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];
    assign rom_data_b = 8'h00;

    // monitor: records handshakes and event times away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) begin
                obs_q.push_back({instr_pc, instr_op, instr_arg});
                obs_cyc.push_back(cyc);
            end
            if (instr_valid_b && instr_ready) obs_b.push_back({pc_b, op_b, arg_b});
            if (state == FETCH_OP && fetch_cyc < 0) fetch_cyc = cyc;
            if (instr_valid && valid_cyc < 0) valid_cyc = cyc;
            if (halted && halt_cyc < 0) halt_cyc = cyc;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        obs_b.delete();
        obs_cyc.delete();
        fetch_cyc = -1;
        valid_cyc = -1;
        halt_cyc  = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        tick(2);
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) tick(1);
    endtask

    task automatic wait_state(input fetch_state_e s, input int budget);
        for (int i = 0; i < budget && state != s; i++) tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({instr_valid, instr_op, instr_arg, instr_pc, halted, fault} !== 27'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v/op/arg/pc/h/f=%h expected 0", {instr_valid, instr_op, instr_arg, instr_pc, halted, fault});
        end
        n_checks++;
        if (rom_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_pc: got %h expected 00", rom_addr);
        end
        rst = 1'b0;
        run = 1'b0;
        tick(3);
        n_checks++;
        if (state !== IDLE || rom_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL idle_hold: got state=%0d pc=%h expected state=0 pc=00", state, rom_addr);
        end
    endtask

    task automatic test_one_byte();
        logic [23:0] e, g;
        do_reset();
        rom[0] = OP_INBOX; rom[1] = OP_OUTBOX; rom[2] = OP_HALT;
        run = 1'b1; instr_ready = 1'b1;
        exp_q.push_back(24'h00_00_00);
        exp_q.push_back(24'h01_10_00);
        exp_q.push_back(24'h02_F0_00);
        wait_halt(60);
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 24'hxxxxxx;
            if (obs_q.size() > 0) g = obs_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL one_byte_issue: got pc/op/arg=%h expected %h", g, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL one_byte_extra_issue: got extra=%0d valid=%b expected 0 0", obs_q.size(), instr_valid);
        end
        n_checks++;
        if (valid_cyc - fetch_cyc != 2) begin
            n_errors++;
            $display("FAIL one_byte_latency: got %0d expected 2", valid_cyc - fetch_cyc);
        end
        n_checks++;
        if (obs_cyc.size() != 3 || obs_cyc[1] - obs_cyc[0] != 3 || halt_cyc - obs_cyc[2] != 1) begin
            n_errors++;
            $display("FAIL one_byte_timing: got n=%0d gap=%0d halt_delay=%0d expected 3 3 1", obs_cyc.size(), obs_cyc[1] - obs_cyc[0], halt_cyc - obs_cyc[2]);
        end
        n_checks++;
        if (state !== HALTED || halted !== 1'b1 || rom_addr !== 8'h03) begin
            n_errors++;
            $display("FAIL one_byte_halted: got state=%0d halted=%b pc=%h expected 6 1 03", state, halted, rom_addr);
        end
    endtask

    task automatic test_two_byte();
        logic [23:0] e, g;
        do_reset();
        rom[0] = OP_COPYFROM; rom[1] = 8'h05; rom[2] = OP_HALT;
        run = 1'b1; instr_ready = 1'b1;
        exp_q.push_back(24'h00_20_05);
        exp_q.push_back(24'h02_F0_00);
        wait_halt(60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 24'hxxxxxx;
            if (obs_q.size() > 0) g = obs_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL two_byte_issue: got pc/op/arg=%h expected %h", g, e);
            end
        end
        n_checks++;
        if (valid_cyc - fetch_cyc != 4) begin
            n_errors++;
            $display("FAIL two_byte_latency: got %0d expected 4", valid_cyc - fetch_cyc);
        end
        n_checks++;
        if (obs_cyc.size() != 2 || obs_cyc[1] - obs_cyc[0] != 3) begin
            n_errors++;
            $display("FAIL two_byte_gap: got n=%0d gap=%0d expected 2 3", obs_cyc.size(), obs_cyc[1] - obs_cyc[0]);
        end
    endtask

    task automatic test_branch();
        logic [23:0] e, g;
        do_reset();
        rom[0] = OP_JUMP; rom[1] = 8'h04; rom[2] = OP_INBOX; rom[3] = OP_INBOX; rom[4] = OP_HALT;
        run = 1'b1; instr_ready = 1'b1;
        branch_taken = 1'b1; branch_target = 8'h04;
        exp_q.push_back(24'h00_80_04);
        exp_q.push_back(24'h04_F0_00);
        wait_halt(60);
        tick(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 24'hxxxxxx;
            if (obs_q.size() > 0) g = obs_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL branch_issue: got pc/op/arg=%h expected %h", g, e);
            end
        end
        // a branch presented with the HALT handshake must not move the PC
        n_checks++;
        if (rom_addr !== 8'h05 || halted !== 1'b1) begin
            n_errors++;
            $display("FAIL branch_on_halt: got pc=%h halted=%b expected 05 1", rom_addr, halted);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_stall();
        logic [23:0] e, g;
        do_reset();
        rom[0] = OP_COPYTO; rom[1] = 8'h07; rom[2] = OP_HALT;
        run = 1'b1; instr_ready = 1'b0;
        branch_target = 8'hAA;
        wait_state(ISSUE, 20);
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 2);
            tick(1);
            n_checks++;
            if (instr_valid !== 1'b1 || {instr_pc, instr_op, instr_arg} !== 24'h00_30_07 || rom_addr !== 8'h02) begin
                n_errors++;
                $display("FAIL stall_hold: got v=%b pc/op/arg=%h rom_addr=%h expected 1 003007 02", instr_valid, {instr_pc, instr_op, instr_arg}, rom_addr);
            end
        end
        branch_taken = 1'b0;
        instr_ready = 1'b1;
        exp_q.push_back(24'h00_30_07);
        exp_q.push_back(24'h02_F0_00);
        wait_halt(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 24'hxxxxxx;
            if (obs_q.size() > 0) g = obs_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL stall_issue: got pc/op/arg=%h expected %h", g, e);
            end
        end
    endtask

    task automatic test_run_low();
        logic [23:0] e, g;
        do_reset();
        rom[0] = OP_COPYFROM; rom[1] = 8'h09; rom[2] = OP_OUTBOX; rom[3] = OP_HALT;
        run = 1'b1; instr_ready = 1'b1;
        wait_state(FETCH_OP, 20);
        run = 1'b0;
        tick(15);
        n_checks++;
        if (state !== IDLE || rom_addr !== 8'h02 || obs_q.size() != 1) begin
            n_errors++;
            $display("FAIL run_low_park: got state=%0d pc=%h issues=%0d expected 0 02 1", state, rom_addr, obs_q.size());
        end
        run = 1'b1;
        exp_q.push_back(24'h00_20_09);
        exp_q.push_back(24'h02_10_00);
        exp_q.push_back(24'h03_F0_00);
        wait_halt(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 24'hxxxxxx;
            if (obs_q.size() > 0) g = obs_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL run_low_issue: got pc/op/arg=%h expected %h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e, g;
        // arrives here parked in HALTED
        rst = 1'b1;
        tick(1);
        n_checks++;
        if (state !== IDLE || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_from_halt: got state=%0d halted=%b expected 0 0", state, halted);
        end
        rst = 1'b0;
        rom[0] = OP_ADD; rom[1] = 8'h05; rom[2] = OP_HALT;
        run = 1'b1; instr_ready = 1'b1;
        wait_state(WAIT_ARG, 20);
        rst = 1'b1;
        tick(1);
        n_checks++;
        if (state !== IDLE || rom_addr !== 8'h00 || instr_valid !== 1'b0 || {instr_pc, instr_op, instr_arg} !== 24'h0 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_fetch: got state=%0d pc=%h v=%b pc/op/arg=%h h=%b expected 0 00 0 000000 0", state, rom_addr, instr_valid, {instr_pc, instr_op, instr_arg}, halted);
        end
        rst = 1'b0;
        clear_obs();
        exp_q.push_back(24'h00_40_05);
        exp_q.push_back(24'h02_F0_00);
        wait_halt(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 24'hxxxxxx;
            if (obs_q.size() > 0) g = obs_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL reset_refetch: got pc/op/arg=%h expected %h", g, e);
            end
        end
    endtask

    task automatic test_bounds();
        logic [23:0] g;
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        tick(30);
`ifdef FETCH_BOUNDS_EN
        n_checks++;
        if (fault_b !== 1'b1 || halted_b !== 1'b1 || state_b !== FAULT || instr_valid_b !== 1'b0) begin
            n_errors++;
            $display("FAIL bounds_fault: got f=%b h=%b state=%0d v=%b expected 1 1 7 0", fault_b, halted_b, state_b, instr_valid_b);
        end
        n_checks++;
        if (obs_b.size() != 3) begin
            n_errors++;
            $display("FAIL bounds_issue_count: got %0d expected 3", obs_b.size());
        end
        for (int i = 0; i < 3; i++) begin
            g = 24'hxxxxxx;
            if (obs_b.size() > 0) g = obs_b.pop_front();
            n_checks++;
            if (g !== {8'(i), 16'h0000}) begin
                n_errors++;
                $display("FAIL bounds_issue: got pc/op/arg=%h expected %h", g, {8'(i), 16'h0000});
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            g = 24'hxxxxxx;
            if (obs_b.size() > 0) g = obs_b.pop_front();
            n_checks++;
            if (g !== {8'(i), 16'h0000}) begin
                n_errors++;
                $display("FAIL nobounds_issue: got pc/op/arg=%h expected %h", g, {8'(i), 16'h0000});
            end
        end
        n_checks++;
        if (fault_b !== 1'b0 || halted_b !== 1'b0) begin
            n_errors++;
            $display("FAIL nobounds_flags: got f=%b h=%b expected 0 0", fault_b, halted_b);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_byte();
        test_branch();
        test_stall();
        test_run_low();
        test_reset_mid();
        test_bounds();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
